// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer: FSM state codes and the
// default counter width.
package debounce_pkg;

  localparam int DEFAULT_CNT_W = 30;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchroniser, press/hold/release FSM with a
// shared stability/hold counter, and a once-per-hold long-press flag.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic [CNT_W-1:0] debounce_max,
  input  logic [CNT_W-1:0] long_max,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse
);

  logic [1:0]       sync_q;
  logic             s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             fired;

  assign s = sync_q[1];

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, which is what makes the two-flop chain
  // a real synchroniser rather than a single wire.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], btn_raw};
  end

  // Pulses default low every cycle and are raised only on the committing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      fired         <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (s) state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt >= debounce_max) begin
            state       <= HELD;
            cnt         <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end else if (cnt >= long_max && !fired) begin
            long_pulse <= 1'b1;
            fired      <= 1'b1;
          end else if (cnt != '1) begin
            // Saturate so a very long hold never wraps back under long_max.
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt >= debounce_max) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
            fired         <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Array of independent debounce channels turning raw bouncing buttons into
// a clean level plus press, release and long-press pulses.
module button_debounce
  import debounce_pkg::*;
#(
  parameter int N_BTN = 5,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [CNT_W-1:0] debounce_max,
  input  logic [CNT_W-1:0] long_max,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(.CNT_W(CNT_W)) u_chan (
      .clk           (clk),
      .rst           (rst),
      .btn_raw       (btn_raw[i]),
      .debounce_max  (debounce_max),
      .long_max      (long_max),
      .btn_level     (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce: reset, press latency,
// bounce rejection, long press, release glitch, zero threshold, mid-run reset.
module tb_button_debounce;
  import debounce_pkg::*;

  localparam int N_BTN = 5;
  localparam int CNT_W = 30;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn_raw;
  logic [CNT_W-1:0] debounce_max;
  logic [CNT_W-1:0] long_max;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] long_pulse;

  int checks = 0;
  int errors = 0;

  button_debounce #(.N_BTN(N_BTN), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .debounce_max  (debounce_max),
    .long_max      (long_max),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    btn_raw = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    debounce_max = 30'd3;
    long_max     = 30'd100;
    rst          = 1'b1;
    btn_raw      = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({btn_level, press_pulse, release_pulse, long_pulse} !== 20'h0) begin
        errors++;
        $display("FAIL reset_outputs: got %h required 0",
                 {btn_level, press_pulse, release_pulse, long_pulse});
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (press_pulse !== ((i == 7) ? 5'b11111 : 5'b00000)) begin
        errors++;
        $display("FAIL reset_fresh_press E%0d: got %b required %b", i, press_pulse,
                 (i == 7) ? 5'b11111 : 5'b00000);
      end
    end
    checks++;
    if (btn_level !== 5'b11111) begin
      errors++;
      $display("FAIL reset_fresh_level: got %b required 11111", btn_level);
    end
  endtask

  task automatic test_press();
    logic [N_BTN-1:0] exp_p, exp_l;
    debounce_max = 30'd3;
    long_max     = 30'd100;
    do_reset();
    btn_raw[0] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      exp_p = (i == 7) ? 5'b00001 : 5'b00000;
      exp_l = (i >= 7) ? 5'b00001 : 5'b00000;
      checks++;
      if (press_pulse !== exp_p || btn_level !== exp_l) begin
        errors++;
        $display("FAIL press_latency E%0d: got p=%b l=%b required p=%b l=%b",
                 i, press_pulse, btn_level, exp_p, exp_l);
      end
    end
  endtask

  task automatic test_bounce();
    debounce_max = 30'd3;
    do_reset();
    btn_raw[0] = 1'b1;
    step();
    step();
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (press_pulse !== 5'b0 || btn_level !== 5'b0) begin
        errors++;
        $display("FAIL bounce_reject: got p=%b l=%b required 0", press_pulse, btn_level);
      end
    end
  endtask

  task automatic test_long();
    int press_cyc = -1, long_cyc = -1, rel_cyc = -1, n_long = 0, n_rel = 0;
    debounce_max = 30'd3;
    long_max     = 30'd10;
    do_reset();
    btn_raw[0] = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (press_pulse[0])   press_cyc = i;
      if (long_pulse[0])    begin long_cyc = i; n_long++; end
      if (release_pulse[0]) begin rel_cyc = i;  n_rel++;  end
      checks++;
      if (((press_pulse & release_pulse) | (press_pulse & long_pulse) |
           (release_pulse & long_pulse)) !== 5'b0) begin
        errors++;
        $display("FAIL long_exclusive E%0d: p=%b r=%b l=%b required disjoint",
                 i, press_pulse, release_pulse, long_pulse);
      end
      if (i == 40) btn_raw[0] = 1'b0;
    end
    checks++;
    if (press_cyc != 7) begin
      errors++; $display("FAIL long_press_cyc: got %0d required 7", press_cyc);
    end
    checks++;
    if (n_long != 1 || long_cyc != 18) begin
      errors++; $display("FAIL long_pulse: got n=%0d at %0d required n=1 at 18", n_long, long_cyc);
    end
    checks++;
    if (n_rel != 1 || rel_cyc != 47) begin
      errors++; $display("FAIL long_release: got n=%0d at %0d required n=1 at 47", n_rel, rel_cyc);
    end
    checks++;
    if (btn_level !== 5'b0) begin
      errors++; $display("FAIL long_level_end: got %b required 0", btn_level);
    end
  endtask

  task automatic test_glitch();
    int n_press = 0, n_rel = 0, n_long = 0;
    debounce_max = 30'd3;
    long_max     = 30'd10;
    do_reset();
    btn_raw[2] = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (press_pulse[2])   n_press++;
      if (release_pulse[2]) n_rel++;
      if (long_pulse[2])    n_long++;
      if (i == 25) btn_raw[2] = 1'b0;
      if (i == 27) btn_raw[2] = 1'b1;
    end
    checks++;
    if (n_press != 1 || n_rel != 0 || n_long != 1) begin
      errors++;
      $display("FAIL glitch_pulses: got press=%0d rel=%0d long=%0d required 1 0 1",
               n_press, n_rel, n_long);
    end
    checks++;
    if (btn_level !== 5'b00100) begin
      errors++; $display("FAIL glitch_level: got %b required 00100", btn_level);
    end
  endtask

  task automatic test_zero_threshold();
    debounce_max = 30'd0;
    long_max     = 30'd100;
    do_reset();
    btn_raw[3] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (press_pulse !== ((i == 4) ? 5'b01000 : 5'b00000)) begin
        errors++;
        $display("FAIL zero_threshold E%0d: got %b required %b", i, press_pulse,
                 (i == 4) ? 5'b01000 : 5'b00000);
      end
    end
  endtask

  task automatic test_reset_mid();
    debounce_max = 30'd3;
    long_max     = 30'd100;
    do_reset();
    btn_raw[1] = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    checks++;
    if ({btn_level, press_pulse, release_pulse, long_pulse} !== 20'h0 ||
        dut.g_ch[1].u_chan.state !== IDLE) begin
      errors++;
      $display("FAIL reset_in_press_wait: got out=%h state=%0d required 0 IDLE",
               {btn_level, press_pulse, release_pulse, long_pulse},
               dut.g_ch[1].u_chan.state);
    end
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    checks++;
    if (press_pulse !== 5'b00010 || btn_level !== 5'b00010) begin
      errors++;
      $display("FAIL reset_repress: got p=%b l=%b required 00010", press_pulse, btn_level);
    end
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    checks++;
    if ({btn_level, press_pulse, release_pulse, long_pulse} !== 20'h0 ||
        dut.g_ch[1].u_chan.state !== IDLE) begin
      errors++;
      $display("FAIL reset_in_held: got out=%h state=%0d required 0 IDLE",
               {btn_level, press_pulse, release_pulse, long_pulse},
               dut.g_ch[1].u_chan.state);
    end
    rst     = 1'b0;
    btn_raw = '0;
  endtask

  initial begin
    rst          = 1'b1;
    btn_raw      = '0;
    debounce_max = '0;
    long_max     = '0;
    test_reset();
    test_press();
    test_bounce();
    test_long();
    test_glitch();
    test_zero_threshold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
